// File: rtl/qfas_seq_if.sv
// qfas_seq_if -- operand/result bundle for the nibble-serial add/subtract unit.
//   start, op, a, b : request side (driven by master)
//   busy, done, y, co, ovf : status/result side (driven by slave)
// NIB sets the number of 4-bit nibbles per operand (W = 4*NIB).
interface qfas_seq_if #(
   parameter int unsigned NIB = 4
);
   localparam int unsigned W = 4 * NIB;

   logic         start;
   logic         op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] y;
   logic         co;
   logic         ovf;

   modport master (
      output start, op, a, b,
      input  busy, done, y, co, ovf
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, y, co, ovf
   );
endinterface

// File: rtl/qfas_seq.sv
// qfas_seq -- nibble-serial add/subtract through one 4-bit slice, LSB nibble first.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   bus       qfas_seq_if.slave: start/op/a/b in, busy/done/y/co/ovf out
// Optional feature: define QFAS_SEQ_OVF_EN to build the signed-overflow flag;
// otherwise ovf is tied to 0 and no overflow logic exists.
module qfas_seq #(
   parameter int unsigned NIB = 4
) (
   input  logic       clk,
   input  logic       rst,
   qfas_seq_if.slave  bus
);
   localparam int unsigned W  = 4 * NIB;
   localparam int unsigned IW = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   state_t        state_nx;
   logic          accept;
   logic          busy_q;
   logic          done_q;

   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic          op_q;
   logic [IW-1:0] idx;
   logic          carry;
   logic [W-1:0]  y_q;
   logic          co_q;

   logic [3:0]    a_nib;
   logic [3:0]    b_sel;
   logic          c_in;
   logic [4:0]    sum;
   logic          last_nib;

   // Slice: current nibble of each operand, B inverted for subtract
   always_comb begin
      a_nib    = 4'(a_q >> {idx, 2'b00});
      b_sel    = 4'(b_q >> {idx, 2'b00});
      if (op_q) b_sel = ~b_sel;
      c_in     = (idx == '0) ? op_q : carry;
      sum      = 5'(a_nib) + 5'(b_sel) + 5'(c_in);
      last_nib = (idx == IW'(NIB - 1));
   end

   // State register; busy/done registered from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nx;
         busy_q <= (state_nx == RUN);
         done_q <= (state_nx == DONE);
      end
   end

   // Next-state logic; a start is accepted in IDLE or DONE, ignored in RUN
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nx = RUN;
               accept   = 1'b1;
            end
         end
         RUN: begin
            if (last_nib) state_nx = DONE;
         end
         DONE: begin
            if (bus.start) begin
               state_nx = RUN;
               accept   = 1'b1;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Datapath: capture on accept, one nibble per RUN edge
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= 1'b0;
         idx   <= '0;
         carry <= 1'b0;
         y_q   <= '0;
         co_q  <= 1'b0;
      end else if (accept) begin
         a_q   <= bus.a;
         b_q   <= bus.b;
         op_q  <= bus.op;
         idx   <= '0;
         carry <= 1'b0;
         y_q   <= '0;
         co_q  <= 1'b0;
      end else if (state == RUN) begin
         // y was cleared on capture, so OR-ing in each nibble is sufficient
         y_q   <= y_q | (W'(sum[3:0]) << {idx, 2'b00});
         carry <= sum[4];
         if (last_nib) co_q <= sum[4];
         else          idx  <= idx + IW'(1);
      end
   end

`ifdef QFAS_SEQ_OVF_EN
   logic ovf_q;
   logic c_msb_in;

   // Carry into the top bit recovered from the slice's bit-3 sum
   assign c_msb_in = a_nib[3] ^ b_sel[3] ^ sum[3];

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (accept) begin
         ovf_q <= 1'b0;
      end else if (state == RUN && last_nib) begin
         ovf_q <= c_msb_in ^ sum[4];
      end
   end

   assign bus.ovf = ovf_q;
`else
   assign bus.ovf = 1'b0;
`endif

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.y    = y_q;
   assign bus.co   = co_q;
endmodule

// File: tb/tb_qfas_seq.sv
// tb_qfas_seq -- directed self-checking bench for qfas_seq at NIB=4.
// Honors QFAS_SEQ_OVF_EN for the expected ovf value.
module tb_qfas_seq;
   localparam int unsigned NIB = 4;
`ifdef QFAS_SEQ_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;

   qfas_seq_if #(.NIB(NIB)) bus ();

   qfas_seq #(.NIB(NIB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full operation: start sampled on E0, busy through E1..E4, done after E4
   task automatic run_op(input string tag, input logic op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] ey,
                         input logic eco, input logic eovf);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      tick();
      bus.start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         check({tag, "_busy"}, 32'(bus.busy), 32'd1);
         check({tag, "_nodone"}, 32'(bus.done), 32'd0);
         tick();
      end
      check({tag, "_done"}, 32'(bus.done), 32'd1);
      check({tag, "_busy0"}, 32'(bus.busy), 32'd0);
      check({tag, "_y"}, 32'(bus.y), 32'(ey));
      check({tag, "_co"}, 32'(bus.co), 32'(eco));
      check({tag, "_ovf"}, 32'(bus.ovf), 32'(eovf));
      tick();
      check({tag, "_done1cyc"}, 32'(bus.done), 32'd0);
      check({tag, "_yhold"}, 32'(bus.y), 32'(ey));
   endtask

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.op    = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      tick();
      tick();
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_y", 32'(bus.y), 32'd0);
      check("rst_co", 32'(bus.co), 32'd0);
      check("rst_ovf", 32'(bus.ovf), 32'd0);
      rst = 1'b0;
      tick();

      run_op("add", 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0);
      run_op("carry", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
      run_op("sub_pos", 1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0);
      run_op("sub_neg", 1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0);
      run_op("ovf_add", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, OVF_EN);
      run_op("ovf_sub", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, OVF_EN);

      // start with new operands during RUN must be ignored
      bus.start = 1'b1;
      bus.op    = 1'b0;
      bus.a     = 16'h0100;
      bus.b     = 16'h0200;
      tick();
      bus.start = 1'b0;
      tick();
      bus.start = 1'b1;
      bus.op    = 1'b1;
      bus.a     = 16'hFFFF;
      bus.b     = 16'hFFFF;
      tick();
      bus.start = 1'b0;
      check("haz_busy", 32'(bus.busy), 32'd1);
      tick();
      tick();
      check("haz_done", 32'(bus.done), 32'd1);
      check("haz_y", 32'(bus.y), 32'h0300);
      check("haz_co", 32'(bus.co), 32'd0);
      tick();

      // Reset on the second RUN edge aborts with no done pulse
      bus.start = 1'b1;
      bus.op    = 1'b0;
      bus.a     = 16'h1111;
      bus.b     = 16'h1111;
      tick();
      bus.start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rrun_busy", 32'(bus.busy), 32'd0);
      check("rrun_done", 32'(bus.done), 32'd0);
      check("rrun_y", 32'(bus.y), 32'd0);
      for (int k = 0; k < 6; k++) begin
         check("rrun_nodone", 32'(bus.done), 32'd0);
         tick();
      end

      // Back-to-back: new start during the DONE cycle
      bus.start = 1'b1;
      bus.op    = 1'b0;
      bus.a     = 16'h1234;
      bus.b     = 16'h0FFF;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      tick();
      tick();
      check("b2b_done1", 32'(bus.done), 32'd1);
      check("b2b_y1", 32'(bus.y), 32'h2233);
      bus.start = 1'b1;
      bus.a     = 16'h0001;
      bus.b     = 16'h0001;
      tick();
      bus.start = 1'b0;
      check("b2b_busy", 32'(bus.busy), 32'd1);
      check("b2b_nodone", 32'(bus.done), 32'd0);
      tick();
      tick();
      tick();
      check("b2b_busy_end", 32'(bus.busy), 32'd1);
      tick();
      check("b2b_done2", 32'(bus.done), 32'd1);
      check("b2b_y2", 32'(bus.y), 32'h0002);
      check("b2b_co2", 32'(bus.co), 32'd0);
      tick();
      check("b2b_idle", 32'(bus.busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/qfas_seq.md
QFAS_SEQ -- requirements
Module: qfas_seq

Interface
REQ-001 The block SHALL have parameter NIB, default 4, giving the number of 4-bit nibbles per operand (operand width W = 4*NIB, legal NIB 1..8).
REQ-002 The block SHALL have one clock, clk, and its reset, rst, SHALL be synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request a new operation; sampled on clk rising edge.
REQ-006 op  input  1  operation select: 0 = add (a+b), 1 = subtract (a-b).
REQ-007 a  input  W  operand A, captured with start.
REQ-008 b  input  W  operand B, captured with start.
REQ-009 busy  output  1  high while nibbles are being processed.
REQ-010 done  output  1  one-cycle pulse when the result is complete.
REQ-011 y  output  W  result.
REQ-012 co  output  1  final carry-out; for subtract, 1 = no borrow.
REQ-013 ovf  output  1  signed two's-complement overflow flag (see REQ-027).

Function
REQ-014 The block SHALL process the operation serially through one internal 4-bit add/subtract slice, one nibble per clock, LSB nibble first.
REQ-015 The slice SHALL compute {c_out, y_nib} = a_nib + (op ? ~b_nib : b_nib) + c_in, in 5-bit unsigned arithmetic.
REQ-016 c_in for nibble 0 SHALL be op; c_in for nibble k>0 SHALL be the registered c_out of nibble k-1.
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-018 IDLE with start=1 SHALL capture a, b and op, clear the nibble index, go to RUN, and clear y, co and ovf, all on the same edge.
REQ-019 RUN SHALL write y[4k+3:4k] and the carry register on each edge; after nibble NIB-1 it SHALL load co and ovf and go to DONE.
REQ-020 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-021 Latency: start is sampled on edge E0 and nibbles are written on E1..ENIB, so done is high during the cycle after ENIB (the cycle after E4 for NIB=4).
REQ-022 DONE SHALL last one cycle; on leaving DONE the block SHALL return to IDLE, or go directly to RUN if start=1 (back-to-back, with a new capture).
REQ-023 start SHALL be ignored while in RUN; the captured operands and op SHALL NOT change during RUN.
REQ-024 y, co and ovf SHALL hold their values from DONE until the next accepted start; y is not valid during RUN.
REQ-025 The nibble index SHALL count 0..NIB-1 and SHALL NOT wrap within one operation.

Reset
REQ-026 rst=1 on any edge, including mid-RUN, SHALL force IDLE with busy=0, done=0, y=0, co=0, ovf=0, nibble index=0 and carry=0; rst SHALL take priority over start.

Configuration
REQ-027 With macro QFAS_SEQ_OVF_EN defined, ovf SHALL be loaded at the final nibble as (carry into bit W-1) XOR (carry out of bit W-1).
REQ-028 Without QFAS_SEQ_OVF_EN, ovf SHALL be constant 0 and no overflow logic SHALL be built; the port list SHALL be identical in both builds.

Verification (NIB=4)
REQ-029 Add: op=0, a=0x1234, b=0x0FFF, start pulsed on E0 -> busy high for E1..E4, done high only in the cycle after E4, y=0x2233, co=0, ovf=0.
REQ-030 Carry chain: op=0, a=0xFFFF, b=0x0001 -> y=0x0000, co=1, ovf=0.
REQ-031 Subtract: op=1, 0x0005-0x0003 -> y=0x0002, co=1; then op=1, 0x0003-0x0005 -> y=0xFFFE, co=0.
REQ-032 Overflow: op=0, 0x7FFF+0x0001 -> y=0x8000, co=0, and ovf=1 with QFAS_SEQ_OVF_EN or ovf=0 without it; op=1, 0x8000-0x0001 -> y=0x7FFF, ovf=1 with the macro.
REQ-033 Hazards: start pulsed with new operands during RUN -> ignored, result from the original operands; rst on the 2nd RUN edge -> IDLE next cycle, busy=0, y=0, no done pulse.
REQ-034 Back-to-back: start=1 during the DONE cycle with 0x0001+0x0001 -> first result shown, busy=1 on the next cycle, second done 5 cycles later with y=0x0002.
